seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised, handshaked ALU for the CPU datapath and for multi-cycle experiments.
- Widens the 4-bit, 4-op combinational ALU to WIDTH bits and 8 base ops, and adds signed overflow and zero flags.
- Shifts are iterative, one bit per cycle; all other base ops complete in one cycle.
- Operands are accepted with a valid/ready handshake, and the result is held in a register until the consumer accepts it.

Parameters:
- WIDTH, 32, operand/result width; legal range 4..64.
- SHW, $clog2(WIDTH), width of the shift-amount field taken from inB[SHW-1:0].

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and op are valid this cycle.
- in_ready  output  1  block can accept a new operation.
- inA  input  WIDTH  operand A.
- inB  input  WIDTH  operand B; low SHW bits are the shift amount for shift ops.
- op  input  4  operation code.
- out_valid  output  1  result/flags are valid.
- out_ready  input  1  consumer accepts the result this cycle.
- ans  output  WIDTH  result.
- zero  output  1  ans == 0.
- ovf  output  1  signed overflow (add/sub only, else 0).
- err  output  1  op code unsupported.

Behaviour:
- One clock, clk; reset is synchronous and active-high, named reset. Sampled only on the rising edge of clk.
- Reset values:
  - state = IDLE, in_ready = 1, out_valid = 0.
  - ans = 0, zero = 0, ovf = 0, err = 0.
  - Internal shift counter = 0.
- Reset has priority over all other inputs. Reset during BUSY or DONE abandons the operation; no result is emitted.
- States are IDLE, BUSY and DONE.
  - in_ready = 1 only in IDLE.
  - out_valid = 1 only in DONE.
- Accept: in IDLE with in_valid = 1, latch inA, inB and op.
- Op codes:
  - 0000 add, 0001 sub, 0010 or, 0011 and.
  - 0100 xor, 0101 sll, 0110 srl, 0111 sra.
- Single-cycle ops (add/sub/or/and/xor, and any shift with amount 0):
  - Result is computed at accept; go IDLE->DONE.
  - out_valid rises the cycle after accept (latency 1).
- Shift with amount N > 0:
  - Go IDLE->BUSY; load the working register with inA and set the counter to N.
  - Each BUSY cycle shifts the working register one bit and decrements the counter.
  - sll fills with 0; srl fills with 0; sra fills with the MSB.
  - When the counter reaches 1 and the last shift completes, go BUSY->DONE.
  - Latency is N+1 cycles from accept to out_valid.
- Arithmetic: modulo 2^WIDTH; carry is discarded.
  - ovf for add: operands have equal signs and the result sign differs.
  - ovf for sub: operands have different signs and the result sign differs from inA.
- zero is computed on the final ans and is valid together with out_valid.
- DONE: ans and flags are held stable while out_ready = 0.
  - out_ready = 1 returns to IDLE the next cycle, with out_valid = 0.
  - No back-to-back accept in the same cycle as out_ready; minimum issue interval is 2 cycles.
- in_valid is ignored outside IDLE; there is no queuing.
- Unsupported op (1xxx when the optional feature is absent, or 1001..1111 when present):
  - Complete in 1 cycle with ans = 0, zero = 1, ovf = 0, err = 1.
- Outputs ans, zero, ovf and err keep their last values in IDLE.

Optional Feature:
- Macro: SEQ_ALU_MUL_EN.
- Defined:
  - op 1000 = unsigned multiply, low WIDTH bits of inA*inB.
  - Implemented shift-add, one partial product per cycle, in state BUSY.
  - Latency WIDTH+1 cycles; ovf = 0; err = 0.
- Undefined:
  - No multiplier logic is synthesised.
  - op 1000 behaves as an unsupported op (err = 1, ans = 0).

Test Plan:
- WIDTH=32; reset held 2 cycles, then released -> in_ready=1, out_valid=0, ans=0, err=0.
- Add: inA=0x7FFFFFFF, inB=1, op=0000 -> one cycle later out_valid=1, ans=0x80000000, ovf=1, zero=0. With out_ready=0 for 3 cycles, ans is held; out_ready=1 gives out_valid=0 next cycle.
- Sub and xor:
  - inA=5, inB=5, op=0001 -> ans=0, zero=1, ovf=0.
  - inA=0xF0F0F0F0, inB=0xFFFFFFFF, op=0100 -> ans=0x0F0F0F0F.
- Shifts:
  - sra: inA=0x80000000, inB=4, op=0111 -> out_valid 5 cycles after accept, ans=0xF8000000. in_ready=0 throughout, and in_valid pulses during BUSY are ignored.
  - sll with inB=0 -> latency 1, ans=inA.
- Mid-operation reset: assert reset in the 3rd BUSY cycle of srl inA=0xFFFFFFFF, inB=31 -> next cycle IDLE, out_valid=0, ans=0; a subsequent add 2+3 returns ans=5.
- Op 1000, inA=7, inB=6:
  - With SEQ_ALU_MUL_EN defined -> ans=42 after 33 cycles, err=0.
  - Without it -> ans=0, err=1 after 1 cycle.

Source files
------------

// File: rtl/seq_alu.sv
// Handshaked WIDTH-bit ALU with iterative shifts and signed overflow / zero flags.
// Define SEQ_ALU_MUL_EN to add a shift-add unsigned multiply on op 1000.
//
// state | meaning
// IDLE  | waiting for in_valid; in_ready high
// BUSY  | iterating a shift (or multiply), one step per cycle
// DONE  | result held on ans/flags until out_ready
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ans,
  output logic             zero,
  output logic             ovf,
  output logic             err
);

  // One extra bit so the counter can also hold WIDTH for the multiply.
  localparam int CW = SHW + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, stateNext;
  logic [WIDTH-1:0] work;
  logic [CW-1:0]    cnt;
  logic [3:0]       opReg;

  logic [SHW-1:0]   shAmt;
  logic             isShift;
  logic             startMulti;
  logic             lastStep;
  logic [WIDTH-1:0] quickAns;
  logic             quickOvf;
  logic             quickErr;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] stepAns;

`ifdef SEQ_ALU_MUL_EN
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mulB;
  logic [WIDTH-1:0] accNext;
  logic             isMul;
  logic             busyMul;

  assign isMul   = (op == 4'b1000);
  assign busyMul = (opReg == 4'b1000);
  assign accNext = mulB[0] ? (acc + work) : acc;
`endif

  assign shAmt    = inB[SHW-1:0];
  assign isShift  = (op == 4'b0101) || (op == 4'b0110) || (op == 4'b0111);
  assign lastStep = (cnt == CW'(1));

`ifdef SEQ_ALU_MUL_EN
  assign startMulti = (isShift && (shAmt != '0)) || isMul;
`else
  assign startMulti = isShift && (shAmt != '0);
`endif

  // Results for everything that completes at accept time.
  always_comb begin
    quickAns = '0;
    quickOvf = 1'b0;
    quickErr = 1'b0;
    case (op)
      4'b0000: begin
        quickAns = inA + inB;
        quickOvf = (inA[WIDTH-1] == inB[WIDTH-1]) && (quickAns[WIDTH-1] != inA[WIDTH-1]);
      end
      4'b0001: begin
        quickAns = inA - inB;
        quickOvf = (inA[WIDTH-1] != inB[WIDTH-1]) && (quickAns[WIDTH-1] != inA[WIDTH-1]);
      end
      4'b0010: quickAns = inA | inB;
      4'b0011: quickAns = inA & inB;
      4'b0100: quickAns = inA ^ inB;
      4'b0101, 4'b0110, 4'b0111: quickAns = inA;
      default: quickErr = 1'b1;
    endcase
  end

  // One iteration step; the multiplicand also walks left, so it shares the sll path.
  always_comb begin
    shifted = work << 1;
    case (opReg)
      4'b0110: shifted = work >> 1;
      4'b0111: shifted = {work[WIDTH-1], work[WIDTH-1:1]};
      default: shifted = work << 1;
    endcase
  end

`ifdef SEQ_ALU_MUL_EN
  assign stepAns = busyMul ? accNext : shifted;
`else
  assign stepAns = shifted;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) stateNext = startMulti ? BUSY : DONE;
      end
      BUSY: begin
        if (lastStep) stateNext = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      work  <= '0;
      cnt   <= '0;
      opReg <= '0;
      ans   <= '0;
      zero  <= 1'b0;
      ovf   <= 1'b0;
      err   <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
      acc   <= '0;
      mulB  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            opReg <= op;
            if (startMulti) begin
              work <= inA;
              cnt  <= CW'(shAmt);
`ifdef SEQ_ALU_MUL_EN
              if (isMul) begin
                cnt  <= CW'(WIDTH);
                acc  <= '0;
                mulB <= inB;
              end
`endif
            end else begin
              ans  <= quickAns;
              zero <= (quickAns == '0);
              ovf  <= quickOvf;
              err  <= quickErr;
            end
          end
        end
        BUSY: begin
          work <= shifted;
          cnt  <= cnt - CW'(1);
`ifdef SEQ_ALU_MUL_EN
          acc  <= accNext;
          mulB <= mulB >> 1;
`endif
          if (lastStep) begin
            ans  <= stepAns;
            zero <= (stepAns == '0);
            ovf  <= 1'b0;
            err  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu at WIDTH=32; honours SEQ_ALU_MUL_EN for op 1000.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] inA;
  logic [31:0] inB;
  logic [3:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ans;
  logic        zero;
  logic        ovf;
  logic        err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] ans;
    logic        zero;
    logic        ovf;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];

  seq_alu #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .inA(inA), .inB(inB), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .ans(ans), .zero(zero), .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] o);
    exp_t e;
    logic [31:0] r;
    logic [4:0] amt;
    amt = b[4:0];
    r = '0;
    e.ovf = 1'b0;
    e.err = 1'b0;
    e.lat = 1;
    case (o)
      4'h0: begin r = a + b; e.ovf = (a[31] == b[31]) && (r[31] != a[31]); end
      4'h1: begin r = a - b; e.ovf = (a[31] != b[31]) && (r[31] != a[31]); end
      4'h2: r = a | b;
      4'h3: r = a & b;
      4'h4: r = a ^ b;
      4'h5: begin r = a << amt; e.lat = int'(amt) + 1; end
      4'h6: begin r = a >> amt; e.lat = int'(amt) + 1; end
      4'h7: begin r = $signed(a) >>> amt; e.lat = int'(amt) + 1; end
`ifdef SEQ_ALU_MUL_EN
      4'h8: begin r = a * b; e.lat = 33; end
`endif
      default: begin r = '0; e.err = 1'b1; end
    endcase
    e.ans  = r;
    e.zero = (r == '0);
    return e;
  endfunction

  task automatic doOp(input logic [31:0] a, input logic [31:0] b, input logic [3:0] o,
                      input int hold, input bit pulse);
    exp_t e;
    int lat;
    @(negedge clk);
    chk("pre_rdy", in_ready, 1);
    inA = a; inB = b; op = o; in_valid = 1'b1;
    sb.push_back(model(a, b, o));
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      chk("busy_rdy", in_ready, 0);
      if (pulse) begin
        in_valid = lat[0];
        inA = ~a; inB = 32'h1; op = 4'h0;
      end
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    e = sb.pop_front();
    chk("timeout", out_valid, 1);
    chk("lat", lat, e.lat);
    chk("ans", ans, e.ans);
    chk("zero", zero, e.zero);
    chk("ovf", ovf, e.ovf);
    chk("err", err, e.err);
    chk("vld_rdy", in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_vld", out_valid, 1);
      chk("hold_ans", ans, e.ans);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("drain_vld", out_valid, 0);
    chk("drain_rdy", in_ready, 1);
    chk("idle_ans", ans, e.ans);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    inA = '0; inB = '0; op = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("rst_rdy", in_ready, 1);
    chk("rst_vld", out_valid, 0);
    chk("rst_ans", ans, 0);
    chk("rst_err", err, 0);
    chk("rst_zero", zero, 0);
    chk("rst_ovf", ovf, 0);

    doOp(32'h7FFFFFFF, 32'h1, 4'h0, 3, 1'b0);
    doOp(32'd5, 32'd5, 4'h1, 0, 1'b0);
    doOp(32'hF0F0F0F0, 32'hFFFFFFFF, 4'h4, 0, 1'b0);
    doOp(32'h80000000, 32'd4, 4'h7, 1, 1'b1);
    doOp(32'h12345678, 32'd0, 4'h5, 0, 1'b0);
    doOp(32'h80000000, 32'd1, 4'h1, 0, 1'b0);
    doOp(32'hA5A5A5A5, 32'h0F0F0F0F, 4'h2, 0, 1'b0);
    doOp(32'hA5A5A5A5, 32'h0F0F0F0F, 4'h3, 0, 1'b0);
    doOp(32'h80000000, 32'd31, 4'h6, 0, 1'b0);
    doOp(32'h00000001, 32'd31, 4'h5, 0, 1'b0);
    doOp(32'h7000000F, 32'hFFFFFFE3, 4'h7, 0, 1'b0);
    doOp(32'hDEADBEEF, 32'h1, 4'hF, 0, 1'b0);

    // Reset lands in the third BUSY cycle of a 31-step srl.
    @(negedge clk);
    inA = 32'hFFFFFFFF; inB = 32'd31; op = 4'h6; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("mid_busy", in_ready, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mid_vld", out_valid, 0);
    chk("mid_rdy", in_ready, 1);
    chk("mid_ans", ans, 0);
    repeat (40) begin
      @(posedge clk); #1;
      chk("mid_quiet", out_valid, 0);
    end
    doOp(32'd2, 32'd3, 4'h0, 0, 1'b0);

    doOp(32'd7, 32'd6, 4'h8, 0, 1'b0);

    for (int k = 0; k < 8; k++) begin
      logic [3:0] rop;
      rop = 4'($urandom_range(0, 7));
      doOp($urandom, $urandom, rop, 0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
